// File: rtl/controller_pkg.sv
// controller_pkg: shared field layout, widths and state encoding for the
// registered instruction decoder (controller_pipe) and its interface.
package controller_pkg;

  // Field widths of the program word.
  localparam int ALUOP_W = 5;
  localparam int ADEV_W  = 3;
  localparam int BDEV_W  = 4;
  localparam int TDEV_W  = 5;
  localparam int COND_W  = 4;
  localparam int FLAG_W  = 10;

  // Number of one-hot selects per bus.
  localparam int ADEV_N = 2 ** ADEV_W;
  localparam int BDEV_N = 2 ** BDEV_W;
  localparam int TDEV_N = 2 ** TDEV_W;

  // Condition selector 0 means "always"; flag input bit 0 is never consulted.
  localparam int COND_ALWAYS = 0;

  // Wait-state counter covers 0..15 extra EXEC cycles.
  localparam int WAIT_W = 4;

  // Fixed part of the word is immed[8] + address[16] + amode + set_flags + invert.
  function automatic int instr_width(input int cond_w, input int bdev_w,
                                     input int adev_w, input int tdev_w,
                                     input int aluop_w);
    return 27 + cond_w + bdev_w + adev_w + tdev_w + aluop_w;
  endfunction

  localparam int INSTR_W = instr_width(COND_W, BDEV_W, ADEV_W, TDEV_W, ALUOP_W);

  // Bit offsets of each field, LSB first.
  localparam int IMMED_LSB  = 0;
  localparam int ADDR_LSB   = 8;
  localparam int AMODE_BIT  = 24;
  localparam int SETF_BIT   = 25;
  localparam int INVERT_BIT = 26;
  localparam int COND_LSB   = 27;
  localparam int BDEV_LSB   = COND_LSB + COND_W;
  localparam int ADEV_LSB   = BDEV_LSB + BDEV_W;
  localparam int TDEV_LSB   = ADEV_LSB + ADEV_W;
  localparam int ALUOP_LSB  = TDEV_LSB + TDEV_W;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_e;

  // Program word, declared MSB first so it overlays the raw word directly.
  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic [TDEV_W-1:0]  targ_dev;
    logic [ADEV_W-1:0]  abus_dev;
    logic [BDEV_W-1:0]  bbus_dev;
    logic [COND_W-1:0]  cond;
    logic               invert;
    logic               set_flags;
    logic               amode;
    logic [15:0]        address;
    logic [7:0]         immed;
  } instr_t;

endpackage

// File: rtl/controller_pipe_if.sv
// controller_pipe_if: program-word / flag inputs and decoded control outputs
// of controller_pipe. master = the controller, slave = ROM/PC/datapath side.
interface controller_pipe_if;
  import controller_pkg::*;

  // Inputs to the controller
  logic [INSTR_W-1:0] instr;
  logic [FLAG_W-1:0]  _flags;
  logic               _hold;

  // Decoded outputs
  logic [7:0]         immed8;
  logic [15:0]        direct_address;
  logic               _addrmode_register;
  logic               _addrmode_direct;
  logic [ALUOP_W-1:0] alu_op;
  logic [ADEV_N-1:0]  _adev_sel;
  logic [BDEV_N-1:0]  _bdev_sel;
  logic [TDEV_N-1:0]  _tdev_sel;
  logic               _set_flags;
  logic               pc_inc;
  logic               exec;

  modport master (
    input  instr, _flags, _hold,
    output immed8, direct_address, _addrmode_register, _addrmode_direct,
           alu_op, _adev_sel, _bdev_sel, _tdev_sel, _set_flags, pc_inc, exec
  );

  modport slave (
    output instr, _flags, _hold,
    input  immed8, direct_address, _addrmode_register, _addrmode_direct,
           alu_op, _adev_sel, _bdev_sel, _tdev_sel, _set_flags, pc_inc, exec
  );

endinterface

// File: rtl/controller_pipe_decoder.sv
// onehot_decoder_n: W-bit index to 2**W active-low one-hot selects, gated by
// an active-low enable. All outputs high while disabled.
module onehot_decoder_n #(
  parameter int W = 3
) (
  input  logic            en_n,
  input  logic [W-1:0]    idx,
  output logic [2**W-1:0] sel_n
);

  // Drive exactly one select low when enabled.
  // NOTE: the all-ones default before the conditional write keeps this purely
  // combinational; without it the untouched bits would infer latches.
  always_comb begin
    sel_n = '1;
    if (!en_n) sel_n[idx] = 1'b0;
  end

endmodule

// File: rtl/controller_pipe.sv
// controller_pipe: registered instruction decoder. Latches the program word
// and flags at FETCH, then decodes them through an EXEC phase lasting
// 1+WAIT_STATES cycles (plus hold cycles). All outputs derive from registered
// state; only _hold reaches the last-cycle strobes combinationally.
// Optional feature macro: CONTROLLER_PIPE_HOLD_EN (enables _hold extension of
// EXEC; when undefined _hold is ignored).
module controller_pipe
  import controller_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input logic               clk,
  input logic               _mr,
  controller_pipe_if.master bus
);

  state_e                 state;
  instr_t                 ir;
  logic [FLAG_W-1:0]      freg;
  logic [WAIT_W-1:0]      wait_cnt;
  logic                   exec_q;

  logic                   in_exec;
  logic                   hold_active;
  logic                   last_cycle;
  logic [2**COND_W-1:0]   flags_ext;
  logic                   cond_met;
  logic                   do_exec;

`ifdef CONTROLLER_PIPE_HOLD_EN
  // A slow target stretches the final EXEC cycle while _hold is low.
  assign hold_active = ~bus._hold;
`else
  assign hold_active = 1'b0;
`endif

  // Sequencer: FETCH captures word/flags/wait count, EXEC counts down and
  // returns to FETCH on its last cycle. Async reset aborts any instruction.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; blocking ones would make ordering matter.
  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      state    <= FETCH;
      ir       <= '0;
      freg     <= '1;
      wait_cnt <= '0;
      exec_q   <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          ir       <= instr_t'(bus.instr);
          freg     <= bus._flags;
          wait_cnt <= WAIT_W'(WAIT_STATES);
          state    <= EXEC;
          exec_q   <= 1'b1;
        end
        EXEC: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end else if (!hold_active) begin
            state  <= FETCH;
            exec_q <= 1'b0;
          end
        end
        default: begin
          state  <= FETCH;
          exec_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_exec    = (state == EXEC);
  assign last_cycle = in_exec && (wait_cnt == '0) && !hold_active;

  // Condition lookup on the flags captured at FETCH: selectors beyond the
  // implemented flags read as inactive (never met); selector 0 always meets.
  always_comb begin
    flags_ext                 = '1;
    flags_ext[FLAG_W-1:0]     = freg;
    flags_ext[COND_ALWAYS]    = 1'b0;
  end

  assign cond_met = ~flags_ext[ir.cond];
  assign do_exec  = cond_met ^ ir.invert;

  // Source buses are selected for the whole EXEC phase.
  onehot_decoder_n #(.W(ADEV_W)) u_adev_dec (
    .en_n  (~in_exec),
    .idx   (ir.abus_dev),
    .sel_n (bus._adev_sel)
  );

  onehot_decoder_n #(.W(BDEV_W)) u_bdev_dec (
    .en_n  (~in_exec),
    .idx   (ir.bbus_dev),
    .sel_n (bus._bdev_sel)
  );

  // Target write happens only in the last EXEC cycle of an executing instruction.
  onehot_decoder_n #(.W(TDEV_W)) u_tdev_dec (
    .en_n  (~(last_cycle & do_exec)),
    .idx   (ir.targ_dev),
    .sel_n (bus._tdev_sel)
  );

  assign bus._set_flags         = ~(last_cycle & do_exec & ir.set_flags);
  assign bus.pc_inc             = last_cycle;
  assign bus.exec               = exec_q;
  assign bus._addrmode_register = ~(in_exec & ~ir.amode);
  assign bus._addrmode_direct   = ~(in_exec & ir.amode);
  assign bus.alu_op             = ir.alu_op;
  assign bus.immed8             = ir.immed;
  assign bus.direct_address     = ir.address;

endmodule

// File: tb/tb_controller_pipe.sv
// tb_controller_pipe: two controller_pipe instances (WAIT_STATES 0 and 2) fed
// the same inputs and compared every cycle against an instruction-level model.
module tb_controller_pipe;
  import controller_pkg::*;

  localparam int NDUT = 2;
  localparam int WS0  = 0;
  localparam int WS1  = 2;
`ifdef CONTROLLER_PIPE_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  adev;
    logic [15:0] bdev;
    logic [31:0] tdev;
    logic        set_flags;
    logic        amode_reg;
    logic        amode_dir;
    logic        pc_inc;
    logic        exec;
    logic [4:0]  alu_op;
    logic [7:0]  immed8;
    logic [15:0] direct_address;
  } obs_t;

  logic clk = 1'b0;
  logic _mr = 1'b1;
  logic [INSTR_W-1:0] instr = '0;
  logic [FLAG_W-1:0]  flags = '1;
  logic               hold  = 1'b1;

  always #5 clk = ~clk;

  controller_pipe_if bus0();
  controller_pipe_if bus1();

  assign bus0.instr  = instr;
  assign bus0._flags = flags;
  assign bus0._hold  = hold;
  assign bus1.instr  = instr;
  assign bus1._flags = flags;
  assign bus1._hold  = hold;

  controller_pipe #(.WAIT_STATES(WS0)) u_dut0 (.clk(clk), ._mr(_mr), .bus(bus0));
  controller_pipe #(.WAIT_STATES(WS1)) u_dut1 (.clk(clk), ._mr(_mr), .bus(bus1));

  obs_t obs [NDUT];
  assign obs[0] = '{adev: bus0._adev_sel, bdev: bus0._bdev_sel, tdev: bus0._tdev_sel,
                    set_flags: bus0._set_flags, amode_reg: bus0._addrmode_register,
                    amode_dir: bus0._addrmode_direct, pc_inc: bus0.pc_inc, exec: bus0.exec,
                    alu_op: bus0.alu_op, immed8: bus0.immed8, direct_address: bus0.direct_address};
  assign obs[1] = '{adev: bus1._adev_sel, bdev: bus1._bdev_sel, tdev: bus1._tdev_sel,
                    set_flags: bus1._set_flags, amode_reg: bus1._addrmode_register,
                    amode_dir: bus1._addrmode_direct, pc_inc: bus1.pc_inc, exec: bus1.exec,
                    alu_op: bus1.alu_op, immed8: bus1.immed8, direct_address: bus1.direct_address};

  // Instruction-level model: phase, captured word/flags, EXEC cycles elapsed.
  bit                 m_fetch [NDUT];
  logic [INSTR_W-1:0] m_ir    [NDUT];
  logic [FLAG_W-1:0]  m_fr    [NDUT];
  int                 m_cyc   [NDUT];

  int pc_cnt [NDUT];
  int strobe_cnt [NDUT];
  int sf_cnt [NDUT];
  int first_pc [NDUT];
  int retired [NDUT];
  int cyc_no;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  // Build a program word from its fields (layout LSB->MSB: immed, address,
  // amode, set_flags, invert, cond, bbus, abus, targ, alu_op).
  function automatic logic [INSTR_W-1:0] mk(input int cond, input bit inv, input bit sf,
                                            input int targ, input int adev, input int bdev,
                                            input int alu, input bit amode);
    logic [INSTR_W-1:0] w;
    w        = '0;
    w[7:0]   = 8'hA5;
    w[23:8]  = 16'h1234;
    w[24]    = amode;
    w[25]    = sf;
    w[26]    = inv;
    w[30:27] = 4'(cond);
    w[34:31] = 4'(bdev);
    w[37:35] = 3'(adev);
    w[42:38] = 5'(targ);
    w[47:43] = 5'(alu);
    return w;
  endfunction

  function automatic obs_t model_out(input int d, input logic hold_in);
    obs_t               e;
    logic [INSTR_W-1:0] w;
    int                 cond;
    bit                 met, do_ex, last;
    w = m_ir[d];
    e = '0;
    e.adev = '1; e.bdev = '1; e.tdev = '1;
    e.set_flags = 1'b1; e.amode_reg = 1'b1; e.amode_dir = 1'b1;
    e.alu_op = w[47:43];
    e.immed8 = w[7:0];
    e.direct_address = w[23:8];
    if (!m_fetch[d]) begin
      e.exec = 1'b1;
      e.adev[w[37:35]] = 1'b0;
      e.bdev[w[34:31]] = 1'b0;
      if (w[24]) e.amode_dir = 1'b0;
      else       e.amode_reg = 1'b0;
      cond = int'(w[30:27]);
      met  = (cond == 0);
      for (int i = 1; i < FLAG_W; i++)
        if (i == cond && m_fr[d][i] == 1'b0) met = 1'b1;
      do_ex = met ^ w[26];
      last  = (m_cyc[d] >= ws_of(d)) && !(HOLD_EN && hold_in == 1'b0);
      if (last) begin
        e.pc_inc = 1'b1;
        if (do_ex) begin
          e.tdev[w[42:38]] = 1'b0;
          if (w[25]) e.set_flags = 1'b0;
        end
      end
    end
    return e;
  endfunction

  task automatic compare(input int d, input obs_t e);
    check($sformatf("dut%0d adev_sel", d),  obs[d].adev, e.adev);
    check($sformatf("dut%0d bdev_sel", d),  obs[d].bdev, e.bdev);
    check($sformatf("dut%0d tdev_sel", d),  obs[d].tdev, e.tdev);
    check($sformatf("dut%0d set_flags", d), obs[d].set_flags, e.set_flags);
    check($sformatf("dut%0d addrmode", d),  {obs[d].amode_reg, obs[d].amode_dir},
                                            {e.amode_reg, e.amode_dir});
    check($sformatf("dut%0d pc_inc", d),    obs[d].pc_inc, e.pc_inc);
    check($sformatf("dut%0d exec", d),      obs[d].exec, e.exec);
    check($sformatf("dut%0d data", d),      {obs[d].alu_op, obs[d].immed8, obs[d].direct_address},
                                            {e.alu_op, e.immed8, e.direct_address});
  endtask

  task automatic clear_stats();
    cyc_no = 0;
    for (int d = 0; d < NDUT; d++) begin
      pc_cnt[d] = 0; strobe_cnt[d] = 0; sf_cnt[d] = 0; first_pc[d] = -1; retired[d] = 0;
    end
  endtask

  // Called just after a negedge with inputs applied; checks, advances the
  // model across the coming posedge, returns just after the next negedge.
  task automatic step();
    obs_t e;
    #1;
    cyc_no++;
    for (int d = 0; d < NDUT; d++) begin
      e = model_out(d, hold);
      compare(d, e);
      if (obs[d].pc_inc) begin
        pc_cnt[d]++;
        if (first_pc[d] < 0) first_pc[d] = cyc_no;
      end
      if (obs[d].tdev != '1) strobe_cnt[d]++;
      if (!obs[d].set_flags) sf_cnt[d]++;
      if (m_fetch[d]) begin
        m_ir[d] = instr; m_fr[d] = flags; m_cyc[d] = 0; m_fetch[d] = 1'b0;
      end else if (e.pc_inc) begin
        m_fetch[d] = 1'b1; retired[d]++;
      end else begin
        m_cyc[d]++;
      end
    end
    @(negedge clk);
  endtask

  // Assert reset between edges, verify outputs clear at once, release on the next negedge.
  task automatic do_reset();
    _mr = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      m_fetch[d] = 1'b1; m_ir[d] = '0; m_fr[d] = '1; m_cyc[d] = 0;
    end
    #1;
    for (int d = 0; d < NDUT; d++) compare(d, model_out(d, hold));
    @(negedge clk);
    _mr = 1'b1;
    clear_stats();
  endtask

  initial begin
    clear_stats();
    @(negedge clk);

    // First instruction after reset: pc_inc on cycle 2 (+wait states).
    instr = '0; flags = '1; hold = 1'b1;
    do_reset();
    repeat (4) step();
    check("first pc_inc ws0", 64'(first_pc[0]), 64'd2);
    check("first pc_inc ws2", 64'(first_pc[1]), 64'd4);

    // Unconditional write to target 7 with flag strobe.
    do_reset();
    instr = mk(0, 1'b0, 1'b1, 7, 2, 9, 21, 1'b1);
    repeat (2) step();
    check("uncond tdev strobes", 64'(strobe_cnt[0]), 64'd1);
    check("uncond set_flags strobes", 64'(sf_cnt[0]), 64'd1);

    // cond=3 with flag inactive at FETCH, going active during EXEC: no write.
    do_reset();
    instr = mk(3, 1'b0, 1'b1, 4, 1, 3, 5, 1'b0);
    flags = '1;
    step();
    flags[3] = 1'b0;
    repeat (3) step();
    check("cond fail no strobe", 64'(strobe_cnt[1]), 64'd0);
    check("cond fail pc_inc", 64'(pc_cnt[1]), 64'd1);

    // Same instruction inverted: write happens.
    do_reset();
    instr = mk(3, 1'b1, 1'b0, 4, 1, 3, 5, 1'b0);
    flags = '1;
    step();
    flags[3] = 1'b0;
    repeat (3) step();
    check("inverted strobe", 64'(strobe_cnt[1]), 64'd1);

    // Hold low for three cycles once the wait states have elapsed.
    do_reset();
    instr = mk(0, 1'b0, 1'b0, 5, 0, 0, 1, 1'b0);
    flags = '1;
    for (int c = 1; c <= 7; c++) begin
      hold = (c >= 4 && c <= 6) ? 1'b0 : 1'b1;
      step();
    end
    hold = 1'b1;
    check("hold pc_inc cycle", 64'(first_pc[1]), HOLD_EN ? 64'd7 : 64'd4);
    check("hold single strobe", 64'(strobe_cnt[1]), 64'd1);

    // Reset in the middle of EXEC, then restart cleanly.
    do_reset();
    instr = mk(0, 1'b0, 1'b1, 7, 4, 4, 9, 1'b1);
    step();
    check("pre-abort strobes", 64'(strobe_cnt[0] + strobe_cnt[1]), 64'd0);
    do_reset();
    repeat (2) step();
    check("restart pc_inc", 64'(first_pc[0]), 64'd2);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      instr = INSTR_W'({$urandom(), $urandom()});
      flags = FLAG_W'($urandom());
      hold  = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 149) == 0) do_reset();
      else step();
    end
    for (int d = 0; d < NDUT; d++)
      check($sformatf("dut%0d pc_inc per instr", d), 64'(pc_cnt[d]), 64'(retired[d]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controller_pipe.md
# controller_pipe

Registered successor to the combinational instruction decoder: latches the program-memory word and the ALU/UART flags into an instruction register at a FETCH phase, then decodes them through an EXEC phase of configurable length. It sits between program ROM/PC and the datapath. It drives one-hot active-low device selects, ALU op, immediate/direct-address outputs and a PC-increment pulse. Condition evaluation uses flags registered at FETCH rather than live flags, which removes the combinational flag→select loop (e.g. UART write conditioned on DO).

## Interface
- ALUOP_W, 5, ALU op field width
- ADEV_W, 3, A-bus device field width; ADEV_N = 2**ADEV_W selects
- BDEV_W, 4, B-bus device field width; BDEV_N = 2**BDEV_W selects
- TDEV_W, 5, target device field width; TDEV_N = 2**TDEV_W selects
- COND_W, 4, condition field width
- FLAG_W, 10, number of active-low flag inputs; index 0 is reserved as "always"
- WAIT_STATES, 0, extra EXEC cycles per instruction (0..15)
- INSTR_W, derived, 27+COND_W+BDEV_W+ADEV_W+TDEV_W+ALUOP_W (48 at defaults)

Ports:
- clk  in  1  system clock, rising edge
- _mr  in  1  master reset; asynchronous, active-low
- instr  in  INSTR_W  program word at current PC. LSB→MSB: immed[8], address[16], amode, set_flags, invert, cond, bbus_dev, abus_dev, targ_dev, alu_op
- _flags  in  FLAG_W  active-low flags; bit 0 is ignored and treated as 0
- _hold  in  1  low extends EXEC (slow target device)
- immed8  out  8  registered immediate
- direct_address  out  16  registered direct address
- _addrmode_register / _addrmode_direct  out  1 each  amode decode, active-low
- alu_op  out  ALUOP_W  registered ALU op
- _adev_sel  out  ADEV_N; _bdev_sel  out  BDEV_N; _tdev_sel  out  TDEV_N  one-hot active-low selects
- _set_flags  out  1  active-low flag-register write strobe
- pc_inc  out  1  one-cycle pulse; PC advances on the next edge
- exec  out  1  high while in EXEC

## Operation
- FSM states: FETCH, EXEC. Reset enters FETCH.
- FETCH lasts 1 cycle. At its closing edge, IR ← instr, FREG ← _flags and wait_cnt ← WAIT_STATES. The FSM then moves to EXEC.
- During FETCH, all selects, _set_flags and both addrmode outputs are high (deasserted), and pc_inc is 0.
- Condition: sel = IR.cond. met = (sel==0) | (sel<FLAG_W & FREG[sel]==0); indices ≥ FLAG_W are never met. do_exec = met XOR IR.invert.
- During all of EXEC: _adev_sel[IR.abus_dev], _bdev_sel[IR.bbus_dev] and the addrmode outputs are asserted. alu_op, immed8 and direct_address are valid.
- Last EXEC cycle is defined as wait_cnt==0 and no active hold. In that cycle only:
  - _tdev_sel[IR.targ_dev] is low if do_exec.
  - _set_flags is low if IR.set_flags and do_exec.
  - pc_inc = 1.
  - The next state is FETCH.
- While wait_cnt>0, wait_cnt decrements each cycle.
- At wait_cnt==0 with _hold low, the FSM stays in EXEC. Target, flag strobes and pc_inc are held off until _hold samples high.
- Flag changes during EXEC do not affect do_exec for the current instruction.

## Timing
- Reset values: IR=0, FREG=all 1s, wait_cnt=0, state FETCH, every active-low output 1, pc_inc=0, exec=0, alu_op=0, immed8=0, direct_address=0.
- Instruction latency: 2+WAIT_STATES cycles, plus any hold cycles.
- Outputs are decoded from registered state only; there is no combinational path from instr or _flags to any output. The only combinational input path is _hold to the last-cycle strobes, when CONTROLLER_PIPE_HOLD_EN is set.
- _mr asserted mid-EXEC clears everything immediately, and a pending target write is suppressed. _mr takes precedence over all other events.
- Exactly one pc_inc per instruction, including instructions whose condition fails.

## Configuration
- CONTROLLER_PIPE_HOLD_EN defined: _hold behaves as specified above.
- Macro undefined: _hold is ignored, and every instruction takes exactly 2+WAIT_STATES cycles.

## Structure
- Package controller_pkg holds:
  - field width and offset localparams
  - the state enum (FETCH, EXEC)
  - COND_ALWAYS=0
  - the INSTR_W derivation function
- Sub-module onehot_decoder_n (parameter W, active-low enable, 2**W active-low outputs) is instanced three times, for adev, bdev and tdev.

## Test plan
- Reset then release, with instr=0: the first pc_inc occurs on cycle 2, and all selects are high throughout FETCH.
- cond=0, targ_dev=7, set_flags=1: in the EXEC cycle, _tdev_sel[7]=0 and _set_flags=0.
- cond=3, _flags[3]=1 at FETCH, _flags[3] driven to 0 during EXEC: no target strobe; pc_inc still pulses.
- Same instruction with invert=1: target strobe occurs.
- WAIT_STATES=2, _hold low for 3 cycles: pc_inc is 1 after exactly 2+2+3=7 cycles, and _tdev_sel is asserted only in that cycle.
- _mr pulsed low during EXEC: all outputs go to reset values within the same cycle, no target strobe occurs, and the sequence restarts at FETCH.
